// File: rtl/bai2_pkg.sv
// Shared types and constants for the BAI2 exhaustive circuit checker.
// State encoding and vector/counter widths.
package bai2_pkg;

    localparam int VEC_W   = 4;
    localparam int NUM_VEC = 16;
    localparam int CNT_W   = 5;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        DONE
    } state_t;

endpackage

// File: rtl/bai2_golden.sv
// Golden reference values for both circuits under test.
// Pure combinational lookup from the current vector.
module bai2_golden
    import bai2_pkg::*;
(
    input  logic [VEC_W-1:0] vec,
    output logic             F,
    output logic             G,
    output logic             Fb
);

    logic a, b, c, d;
    logic abc;

    assign a   = vec[3];
    assign b   = vec[2];
    assign c   = vec[1];
    assign d   = vec[0];
    assign abc = a & b & c;

    // x, y of the 2-input circuit are vec[1], vec[0]
    assign F  = (~a & d) | abc;
    assign G  = (~a & ~d) | abc;
    assign Fb = ~(c ^ d);

endmodule

// File: rtl/bai2_ctrl.sv
// Walks all 16 vectors through two circuits under test and
// counts vectors whose sampled outputs disagree with golden.
module bai2_ctrl
    import bai2_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       F,
    input  logic       G,
    input  logic       Fb,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       D,
    output logic       x,
    output logic       y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_cnt,
    output logic [3:0] first_fail_vec,
    output logic       first_fail_valid
);

    localparam logic [3:0]       SET_LAST = 4'(SETTLE - 1);
    localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VEC - 1);

    state_t           state;
    state_t           state_nxt;
    logic [VEC_W-1:0] vec;
    logic [3:0]       scnt;
    logic             g_f, g_g, g_fb;
    logic             fail;
    logic [CNT_W-1:0] err_nxt;

    bai2_golden u_golden (
        .vec (vec),
        .F   (g_f),
        .G   (g_g),
        .Fb  (g_fb)
    );

    assign fail    = (F != g_f) | (G != g_g) | (Fb != g_fb);
    assign err_nxt = err_cnt + CNT_W'(fail);

    // vec is zeroed on every exit to IDLE/DONE, so stimulus idles low
    assign A = vec[3];
    assign B = vec[2];
    assign C = vec[1];
    assign D = vec[0];
    assign x = vec[1];
    assign y = vec[0];

    assign busy = (state == DRIVE) || (state == SAMPLE);
    assign done = (state == DONE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; abort overrides everything
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_nxt = DRIVE;
                DRIVE:   if (scnt == SET_LAST) state_nxt = SAMPLE;
                SAMPLE:  state_nxt = (vec == LAST_VEC) ? DONE : DRIVE;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Vector, settle counter and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec              <= '0;
            scnt             <= '0;
            err_cnt          <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
            pass             <= 1'b0;
        end else if (abort) begin
            vec              <= '0;
            scnt             <= '0;
            err_cnt          <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
            pass             <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        vec              <= '0;
                        scnt             <= '0;
                        err_cnt          <= '0;
                        first_fail_vec   <= '0;
                        first_fail_valid <= 1'b0;
                        pass             <= 1'b0;
                    end
                end
                DRIVE: begin
                    scnt <= (scnt == SET_LAST) ? 4'd0 : scnt + 4'd1;
                end
                SAMPLE: begin
                    err_cnt <= err_nxt;
                    if (fail && !first_fail_valid) begin
                        first_fail_vec   <= vec;
                        first_fail_valid <= 1'b1;
                    end
                    if (vec == LAST_VEC) begin
                        vec  <= '0;
                        pass <= (err_nxt == '0);
                    end else begin
                        vec <= vec + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bai2_ctrl.sv
// Bench for bai2_ctrl: fault-injecting circuit models and
// a scoreboard of expected run results.
module tb_bai2_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;

    logic       start1 = 1'b0, abort1 = 1'b0;
    logic       f1, g1, fb1;
    logic       a1, b1, c1, d1, x1, y1;
    logic       busy1, done1, pass1, ffok1;
    logic [4:0] err1;
    logic [3:0] ffv1;

    logic       start3 = 1'b0, abort3 = 1'b0;
    logic       f3, g3, fb3;
    logic       a3, b3, c3, d3, x3, y3;
    logic       busy3, done3, pass3, ffok3;
    logic [4:0] err3;
    logic [3:0] ffv3;

    int mode = 0;
    int total = 0;
    int bad = 0;

    typedef struct {
        int   err;
        int   ffv;
        logic ffok;
        logic pass;
        int   lat;
    } exp_t;

    exp_t sb[$];

    bai2_ctrl #(.SETTLE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
        .F(f1), .G(g1), .Fb(fb1),
        .A(a1), .B(b1), .C(c1), .D(d1), .x(x1), .y(y1),
        .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
        .first_fail_vec(ffv1), .first_fail_valid(ffok1)
    );

    bai2_ctrl #(.SETTLE(3)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3),
        .F(f3), .G(g3), .Fb(fb3),
        .A(a3), .B(b3), .C(c3), .D(d3), .x(x3), .y(y3),
        .busy(busy3), .done(done3), .pass(pass3), .err_cnt(err3),
        .first_fail_vec(ffv3), .first_fail_valid(ffok3)
    );

    // Correct circuit behaviour: {F, G, Fb}
    function automatic logic [2:0] circ(input logic [3:0] v);
        logic a, b, c, d, f, g, fb;
        a  = v[3]; b = v[2]; c = v[1]; d = v[0];
        f  = (!a && d) || (a && b && c);
        g  = (!a && !d) || (a && b && c);
        fb = (c == d);
        return {f, g, fb};
    endfunction

    logic [3:0] v1;
    logic [2:0] r1;

    // Circuit seen by u1, with the selected fault applied
    always_comb begin
        v1 = {a1, b1, c1, d1};
        r1 = circ(v1);
        case (mode)
            1: r1[1] = 1'b0;
            2: r1[0] = ~r1[0];
            3: r1[2] = 1'b1;
            4: if (v1 == 4'd9) r1[0] = ~r1[0];
            5: begin
                if (v1 == 4'd5) r1[1] = ~r1[1];
                if (v1 == 4'd12) r1 = ~r1;
            end
            default: ;
        endcase
        {f1, g1, fb1} = r1;
    end

    // u3 always sees a fault-free circuit
    always_comb begin
        {f3, g3, fb3} = circ({a3, b3, c3, d3});
    end

    task automatic run1(input int m, input int e, input int fv,
                        input logic fok);
        exp_t       ex;
        exp_t       got;
        int         cyc;
        logic [3:0] ev;
        mode    = m;
        ex.err  = e;
        ex.ffv  = fv;
        ex.ffok = fok;
        ex.pass = (e == 0);
        ex.lat  = 33;
        sb.push_back(ex);
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        cyc = 1;
        total++;
        if (busy1 !== 1'b1 || pass1 !== 1'b0 || err1 !== 5'd0) begin
            bad++;
            $display("FAIL start_clear m=%0d busy=%b pass=%b err=%0d exp 1/0/0",
                     m, busy1, pass1, err1);
        end
        while (done1 !== 1'b1 && cyc < 200) begin
            ev = 4'((cyc - 1) / 2);
            total++;
            if ({a1, b1, c1, d1} !== ev || {x1, y1} !== ev[1:0]) begin
                bad++;
                $display("FAIL vec_out cyc=%0d got=%b%b%b%b xy=%b%b exp=%b",
                         cyc, a1, b1, c1, d1, x1, y1, ev);
            end
            @(negedge clk);
            cyc++;
        end
        got = sb.pop_front();
        total++;
        if (cyc !== got.lat) begin
            bad++;
            $display("FAIL latency m=%0d got=%0d exp=%0d", m, cyc, got.lat);
        end
        total++;
        if (err1 !== 5'(got.err)) begin
            bad++;
            $display("FAIL err_cnt m=%0d got=%0d exp=%0d", m, err1, got.err);
        end
        total++;
        if (ffok1 !== got.ffok || ffv1 !== 4'(got.ffv)) begin
            bad++;
            $display("FAIL first_fail m=%0d got=%b/%0d exp=%b/%0d",
                     m, ffok1, ffv1, got.ffok, got.ffv);
        end
        total++;
        if (pass1 !== got.pass) begin
            bad++;
            $display("FAIL pass m=%0d got=%b exp=%b", m, pass1, got.pass);
        end
        total++;
        if (busy1 !== 1'b0 || {a1, b1, c1, d1, x1, y1} !== 6'd0) begin
            bad++;
            $display("FAIL done_idle m=%0d busy=%b stim=%b%b%b%b%b%b exp 0",
                     m, busy1, a1, b1, c1, d1, x1, y1);
        end
        @(negedge clk);
        total++;
        if (done1 !== 1'b0 || pass1 !== got.pass) begin
            bad++;
            $display("FAIL after_done m=%0d done=%b pass=%b exp 0/%b",
                     m, done1, pass1, got.pass);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy1, done1, pass1, ffok1, err1, ffv1,
             a1, b1, c1, d1, x1, y1} !== '0) begin
            bad++;
            $display("FAIL reset_state got busy=%b done=%b pass=%b err=%0d ffv=%0d exp 0",
                     busy1, done1, pass1, err1, ffv1);
        end
        @(negedge clk) rst_n = 1'b1;
        mode = 1;
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({busy1, done1, pass1, ffok1, err1, ffv1,
             a1, b1, c1, d1, x1, y1} !== '0) begin
            bad++;
            $display("FAIL reset_midrun got busy=%b err=%0d ffok=%b stim=%b%b%b%b exp 0",
                     busy1, err1, ffok1, a1, b1, c1, d1);
        end
        @(negedge clk) rst_n = 1'b1;
        run1(0, 0, 0, 1'b0);
    endtask

    task automatic test_faults();
        run1(1, 6, 0, 1'b1);
        run1(2, 16, 0, 1'b1);
        run1(3, 10, 0, 1'b1);
        run1(4, 1, 9, 1'b1);
        run1(5, 2, 5, 1'b1);
    endtask

    task automatic test_abort();
        int seen;
        mode = 1;
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        repeat (9) @(negedge clk);
        abort1 = 1'b1;
        @(negedge clk) abort1 = 1'b0;
        total++;
        if (busy1 !== 1'b0 || done1 !== 1'b0 || err1 !== 5'd0 ||
            ffok1 !== 1'b0 || {a1, b1, c1, d1, x1, y1} !== 6'd0) begin
            bad++;
            $display("FAIL abort busy=%b done=%b err=%0d ffok=%b stim=%b%b%b%b exp 0",
                     busy1, done1, err1, ffok1, a1, b1, c1, d1);
        end
        seen = 0;
        repeat (50) begin
            @(negedge clk);
            if (done1 === 1'b1 || busy1 === 1'b1) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL abort_quiet got=%0d active cycles exp=0", seen);
        end
        @(negedge clk) begin
            start1 = 1'b1;
            abort1 = 1'b1;
        end
        @(negedge clk) begin
            start1 = 1'b0;
            abort1 = 1'b0;
        end
        seen = 0;
        repeat (40) begin
            if (done1 === 1'b1 || busy1 === 1'b1) seen++;
            @(negedge clk);
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL abort_wins got=%0d active cycles exp=0", seen);
        end
    endtask

    task automatic test_settle3();
        exp_t ex;
        exp_t got;
        int   cyc;
        int   seen;
        ex.err  = 0;
        ex.ffv  = 0;
        ex.ffok = 1'b0;
        ex.pass = 1'b1;
        ex.lat  = 65;
        sb.push_back(ex);
        @(negedge clk) start3 = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            start3 = (cyc == 5 || cyc == 20);
        end while (done3 !== 1'b1 && cyc < 300);
        start3 = 1'b0;
        got = sb.pop_front();
        total++;
        if (cyc !== got.lat) begin
            bad++;
            $display("FAIL s3_latency got=%0d exp=%0d", cyc, got.lat);
        end
        total++;
        if (err3 !== 5'(got.err) || pass3 !== got.pass || ffok3 !== got.ffok) begin
            bad++;
            $display("FAIL s3_result err=%0d pass=%b ffok=%b exp %0d/%b/%b",
                     err3, pass3, ffok3, got.err, got.pass, got.ffok);
        end
        seen = 0;
        repeat (80) begin
            @(negedge clk);
            if (done3 === 1'b1 || busy3 === 1'b1) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL s3_restart got=%0d active cycles exp=0", seen);
        end
    endtask

    task automatic test_back_to_back();
        run1(0, 0, 0, 1'b0);
        run1(3, 10, 0, 1'b1);
        run1(0, 0, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_faults();
        test_abort();
        test_settle3();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bai2_ctrl.md
BAI2_CTRL -- requirements
Module: bai2_ctrl

Interface
REQ-001 SHALL have parameter: SETTLE, 1, number of DRIVE cycles per vector (legal range 1..15).
REQ-002 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: start  in  1  run request, sampled in IDLE only.
REQ-005 SHALL have port: abort  in  1  terminate run, sampled in any state.
REQ-006 SHALL have port: F, G  in  1 each  outputs of the 4-input gate circuit under test.
REQ-007 SHALL have port: Fb  in  1  output of the 2-input NOR-network circuit under test.
REQ-008 SHALL have port: A, B, C, D  out  1 each  stimulus to the 4-input circuit, equal to vec[3], vec[2], vec[1], vec[0].
REQ-009 SHALL have port: x, y  out  1 each  stimulus to the 2-input circuit, equal to vec[1], vec[0].
REQ-010 SHALL have port: busy  out  1  high from the edge after start is accepted until DONE is entered.
REQ-011 SHALL have port: done  out  1  one-cycle pulse in DONE.
REQ-012 SHALL have port: pass  out  1  high when err_cnt==0; valid from done until the next start.
REQ-013 SHALL have port: err_cnt  out  5  number of failing vectors (0..16).
REQ-014 SHALL have port: first_fail_vec  out  4  lowest-index failing vector; first_fail_valid  out  1  its qualifier.

Function
REQ-015 SHALL implement FSM states IDLE, DRIVE, SAMPLE, DONE.
REQ-016 IDLE: start=1 and abort=0 -> DRIVE; vec<=0; err_cnt<=0; first_fail_valid<=0; pass<=0; settle counter<=0.
REQ-017 DRIVE SHALL hold vec on A..D, x, y for exactly SETTLE cycles, then -> SAMPLE.
REQ-018 SAMPLE SHALL compare {F,G,Fb} against golden values for vec in one cycle.
REQ-019 SHALL use golden values F=(~A&D)|(A&B&C), G=(~A&~D)|(A&B&C), Fb=~(x^y).
REQ-020 A vector SHALL count as one failure if any of the three bits mismatches; err_cnt increments by at most 1 per vector.
REQ-021 On the first failure of a run, first_fail_vec<=vec and first_fail_valid<=1; later failures leave both unchanged.
REQ-022 SAMPLE: vec==15 -> DONE (no wrap); otherwise vec<=vec+1 -> DRIVE.
REQ-023 DONE SHALL last one cycle with done=1 and busy=0, then -> IDLE; pass=(err_cnt==0) is registered on DONE entry.
REQ-024 Latency: done SHALL be high in cycle 16*(SETTLE+1)+1 after the start-accept edge (cycle 33 for SETTLE=1).
REQ-025 start while not in IDLE SHALL be ignored.
REQ-026 abort=1 in any state SHALL force IDLE on the next edge: busy=0, no done pulse, vec/A..D/x/y=0, results cleared.
REQ-027 abort and start high in the same IDLE cycle: abort wins; no run starts.
REQ-028 A..D, x, y SHALL be registered outputs; they are 0 in IDLE and DONE.

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE and all outputs to 0, including pass, err_cnt, first_fail_vec, and first_fail_valid.
REQ-030 Reset mid-run SHALL discard the run; the first edge after rst_n rises SHALL be treated as IDLE.

Structure
REQ-031 Package bai2_pkg SHALL hold the state encoding, VEC_W=4, NUM_VEC=16, and CNT_W=5.
REQ-032 Golden-value logic SHALL be in one combinational sub-module, bai2_golden (in vec[3:0]; out F, G, Fb).

Verification
REQ-033 Reset: rst_n=0 mid-run at cycle 7 -> all outputs 0 immediately; start after release runs normally.
REQ-034 F, G, Fb driven by correct models, SETTLE=1, start pulse -> done at cycle 33, pass=1, err_cnt=0, first_fail_valid=0.
REQ-035 G stuck-at-0 -> err_cnt=6 (vectors 0, 2, 4, 6, 14, 15), first_fail_vec=0, pass=0.
REQ-036 Fb inverted -> err_cnt=16, first_fail_vec=0; F stuck-at-1 only -> err_cnt=10, first_fail_vec=0.
REQ-037 abort at cycle 10 -> busy=0 at cycle 11, no done, A..D=0; start in the same cycle as abort is ignored.
REQ-038 SETTLE=3 with start re-pulsed while busy -> single run, done at cycle 65, second start ignored.
